// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the UART loopback byte FIFO.
//
// Contents:
//   BYTE_W        - width of one UART data byte
//   drain_state_t - states of the FIFO drain controller in uart_tx_fifo
package uart_pkg;

   localparam int unsigned BYTE_W = 8;

   // Drain controller states:
   //   StIdle     - waiting for a queued byte and an idle transmitter
   //   StLaunch   - send strobe is high for exactly this cycle
   //   StWaitBusy - waiting for the transmitter to acknowledge by raising busy
   //   StWaitDone - waiting for the transmitter frame to finish
   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StLaunch   = 2'd1,
      StWaitBusy = 2'd2,
      StWaitDone = 2'd3
   } drain_state_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: DEPTH x BYTE_W storage array for the UART transmit FIFO.
//
// Synchronous write, asynchronous (combinational) read. The array has no
// reset; entries only become visible through the pointers owned by the
// parent, so stale contents are never observed.
//
// Ports:
//   clk   - clock
//   we    - write enable, stores wdata at waddr on the rising edge
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data, combinational from raddr
module uart_fifo_ram
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [BYTE_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [BYTE_W-1:0] rdata
);

   logic [BYTE_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus drain controller between uart_rx and uart_tx.
//
// Bytes strobed in by the receiver are queued; the drain FSM issues one
// single-cycle send strobe per byte and waits for the transmitter to go busy
// and then idle again before launching the next one.
//
// Build option: define UART_FIFO_OVERFLOW_EN to get the sticky overflow flag
// and its clear input. Without it overflow_o is tied low, clr_i is ignored,
// and bytes written while full are still dropped.
//
// Ports:
//   clk        - clock
//   resetn     - asynchronous active-low reset
//   wr_e_i     - one-cycle write strobe (uart_rx done_o)
//   wr_d_i     - write byte, valid with wr_e_i (uart_rx d_o)
//   tx_busy_i  - transmitter busy (uart_tx busy_o)
//   clr_i      - clears the sticky overflow flag
//   tx_e_o     - one-cycle send strobe (uart_tx e_i)
//   tx_d_o     - byte to send, held from the strobe until the next launch
//   count_o    - current occupancy, 0..DEPTH
//   empty_o    - occupancy is zero
//   full_o     - occupancy equals DEPTH
//   overflow_o - sticky, set when a byte was dropped
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   wr_e_i,
   input  logic [BYTE_W-1:0]      wr_d_i,
   input  logic                   tx_busy_i,
   input  logic                   clr_i,
   output logic                   tx_e_o,
   output logic [BYTE_W-1:0]      tx_d_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic                   overflow_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   drain_state_t state_q, state_d;

   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic              tx_e_q;
   logic [BYTE_W-1:0] tx_d_q;
   logic [BYTE_W-1:0] head;
   logic              empty, full;
   logic              pop, push;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_COUNT);

   // -----------------------------------------------------------------------
   // Storage
   // -----------------------------------------------------------------------
   uart_fifo_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (wr_d_i),
      .raddr (rd_ptr_q),
      .rdata (head)
   );

   // -----------------------------------------------------------------------
   // Drain FSM
   // -----------------------------------------------------------------------
   // The pop is tied to the Idle->Launch transition so the head byte lands in
   // tx_d_q on the same edge that raises the send strobe.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty && !tx_busy_i) begin
               state_d = StLaunch;
               pop     = 1'b1;
            end
         end
         StLaunch: begin
            state_d = StWaitBusy;
         end
         StWaitBusy: begin
            if (tx_busy_i) begin
               state_d = StWaitDone;
            end
         end
         StWaitDone: begin
            if (!tx_busy_i) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // -----------------------------------------------------------------------
   // Pointers, occupancy and transmit registers
   // -----------------------------------------------------------------------
   // A full FIFO still accepts a write when the head leaves in the same
   // cycle; the slot being written is the one just read out.
   assign push = wr_e_i && (!full || pop);

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         tx_e_q   <= 1'b0;
         tx_d_q   <= '0;
      end else begin
         count_q <= count_d;
         tx_e_q  <= pop;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            tx_d_q   <= head;
         end
      end
   end

   // -----------------------------------------------------------------------
   // Overflow flag
   // -----------------------------------------------------------------------
`ifdef UART_FIFO_OVERFLOW_EN
   logic drop;
   logic overflow_q;

   assign drop = wr_e_i && full && !pop;

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end else if (clr_i) begin
         overflow_q <= 1'b0;
      end
   end

   assign overflow_o = overflow_q;
`else
   logic unused_clr;

   assign unused_clr = clr_i;
   assign overflow_o = 1'b0;
`endif

   // -----------------------------------------------------------------------
   // Outputs
   // -----------------------------------------------------------------------
   assign tx_e_o  = tx_e_q;
   assign tx_d_o  = tx_d_q;
   assign count_o = count_q;
   assign empty_o = empty;
   assign full_o  = full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo (DEPTH = 16).
module tb_uart_tx_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int          FRAME = 10;
   localparam int          NVEC  = 19;
`ifdef UART_FIFO_OVERFLOW_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       resetn;
   logic       wr_e;
   logic [7:0] wr_d;
   logic       busy_drv;
   logic       model_en;
   logic       tx_busy;
   logic       clr;
   logic       tx_e;
   logic [7:0] tx_d;
   logic [4:0] count;
   logic       empty;
   logic       full;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   uart_tx_fifo #(
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .wr_e_i     (wr_e),
      .wr_d_i     (wr_d),
      .tx_busy_i  (tx_busy),
      .clr_i      (clr),
      .tx_e_o     (tx_e),
      .tx_d_o     (tx_d),
      .count_o    (count),
      .empty_o    (empty),
      .full_o     (full),
      .overflow_o (overflow)
   );

   always #5 clk = ~clk;

   // Transmitter model: busy rises the cycle after the strobe is sampled and
   // stays high for FRAME cycles.
   int   frame_cnt;
   logic model_busy;
   assign model_busy = (frame_cnt != 0);
   assign tx_busy    = model_en ? model_busy : busy_drv;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         frame_cnt <= 0;
      end else if (frame_cnt != 0) begin
         frame_cnt <= frame_cnt - 1;
      end else if (tx_e && model_en) begin
         frame_cnt <= FRAME;
      end
   end

   // Monitor: every sampled send strobe and its byte.
   logic [7:0] got[$];
   int         busy_at_launch;

   always @(posedge clk) begin
      if (tx_e) begin
         got.push_back(tx_d);
         if (tx_busy) busy_at_launch <= busy_at_launch + 1;
      end
   end

   typedef struct {
      logic       wr_e;
      logic [7:0] wr_d;
      logic       busy;
      logic       tx_e;
      logic [7:0] tx_d;
      logic [4:0] count;
      logic       empty;
      logic       full;
   } vec_t;

   vec_t vecs[NVEC];

   function automatic vec_t mk(logic we, logic [7:0] wd, logic b, logic te, logic [7:0] td,
                               logic [4:0] c, logic em, logic fu);
      vec_t v;
      v.wr_e = we; v.wr_d = wd; v.busy = b;
      v.tx_e = te; v.tx_d = td; v.count = c; v.empty = em; v.full = fu;
      return v;
   endfunction

   function automatic logic [31:0] outs();
      return {15'd0, tx_e, tx_d, count, empty, full, overflow};
   endfunction

   function automatic logic [31:0] expv(logic te, logic [7:0] td, logic [4:0] c, logic em,
                                        logic fu, logic ov);
      return {15'd0, te, td, c, em, fu, ov};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_got(input int n, input int budget, input string name);
      for (int t = 0; t < budget && got.size() < n; t++) cycle();
      check(name, 32'(got.size()), 32'(n));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Directed per-cycle vectors: {wr_e, wr_d, busy} -> outputs after the edge.
      vecs[0]  = mk(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0);
      vecs[1]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0);
      vecs[2]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0);
      vecs[3]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0);
      vecs[4]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0);
      vecs[5]  = mk(1'b1, 8'h01, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0);
      vecs[6]  = mk(1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 5'd1, 1'b0, 1'b0);
      vecs[7]  = mk(1'b1, 8'h03, 1'b0, 1'b0, 8'h01, 5'd2, 1'b0, 1'b0);
      vecs[8]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 5'd2, 1'b0, 1'b0);
      vecs[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 5'd2, 1'b0, 1'b0);
      vecs[10] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h02, 5'd1, 1'b0, 1'b0);
      vecs[11] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 5'd1, 1'b0, 1'b0);
      vecs[12] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 5'd1, 1'b0, 1'b0);
      vecs[13] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h02, 5'd1, 1'b0, 1'b0);
      vecs[14] = mk(1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 5'd0, 1'b1, 1'b0);
      vecs[15] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 5'd0, 1'b1, 1'b0);
      vecs[16] = mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h03, 5'd0, 1'b1, 1'b0);
      vecs[17] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 5'd0, 1'b1, 1'b0);
      vecs[18] = mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h03, 5'd0, 1'b1, 1'b0);

      resetn = 1'b0; wr_e = 1'b0; wr_d = 8'h00; clr = 1'b0;
      busy_drv = 1'b0; model_en = 1'b0; busy_at_launch = 0;

      #12;
      check("reset_values", outs(), expv(1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
      resetn = 1'b1;
      cycle();
      check("idle_after_reset", outs(), expv(1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0));

      // Single byte, write-and-pop at same cycle, FSM handshake.
      for (int i = 0; i < NVEC; i++) begin
         wr_e     = vecs[i].wr_e;
         wr_d     = vecs[i].wr_d;
         busy_drv = vecs[i].busy;
         cycle();
         check($sformatf("vec%0d", i), outs(),
               expv(vecs[i].tx_e, vecs[i].tx_d, vecs[i].count, vecs[i].empty, vecs[i].full,
                    1'b0));
      end
      wr_e = 1'b0;

      // Burst while busy, then drain with 10-cycle frames.
      busy_drv = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         wr_e = 1'b1; wr_d = 8'(k);
         cycle();
      end
      wr_e = 1'b0;
      cycle();
      check("burst_count", outs(), expv(1'b0, 8'h03, 5'd4, 1'b0, 1'b0, 1'b0));
      got.delete();
      busy_at_launch = 0;
      model_en = 1'b1;
      wait_got(4, 300, "burst_strobes");
      for (int k = 0; k < 4; k++)
         check($sformatf("burst_byte%0d", k), 32'(got[k]), 32'(k + 1));
      repeat (20) cycle();
      check("burst_launch_while_busy", 32'(busy_at_launch), 32'd0);
      check("burst_drained", 32'(count), 32'd0);

      // Fill and overflow.
      model_en = 1'b0; busy_drv = 1'b1;
      for (int k = 0; k < 17; k++) begin
         wr_e = 1'b1; wr_d = 8'(8'h10 + k);
         cycle();
      end
      wr_e = 1'b0;
      check("fill_full", outs(), expv(1'b0, 8'h04, 5'd16, 1'b0, 1'b1, OVF_EXP));
      clr = 1'b1; cycle(); clr = 1'b0;
      check("clr_overflow", 32'(overflow), 32'd0);
      // Drop and clear together: set wins.
      wr_e = 1'b1; wr_d = 8'hEE; clr = 1'b1;
      cycle();
      wr_e = 1'b0; clr = 1'b0;
      check("drop_clr_same_cycle", outs(), expv(1'b0, 8'h04, 5'd16, 1'b0, 1'b1, OVF_EXP));
      clr = 1'b1; cycle(); clr = 1'b0;
      check("clr_again", 32'(overflow), 32'd0);

      // Write at full in the same cycle as the pop.
      got.delete();
      busy_drv = 1'b0; wr_e = 1'b1; wr_d = 8'hAA;
      cycle();
      wr_e = 1'b0;
      model_en = 1'b1;
      check("full_write_pop", outs(), expv(1'b1, 8'h10, 5'd16, 1'b0, 1'b1, 1'b0));
      wait_got(17, 600, "full_drain_strobes");
      for (int k = 0; k < 16; k++)
         check($sformatf("full_byte%0d", k), 32'(got[k]), 32'(8'h10 + k));
      check("full_last_byte", 32'(got[16]), 32'h0000_00AA);
      repeat (20) cycle();

      // Wrap-around stream of 40 bytes.
      got.delete();
      begin
         int sent;
         sent = 0;
         for (int t = 0; t < 3000 && sent < 40; t++) begin
            if (count < 5'd12) begin
               wr_e = 1'b1; wr_d = 8'(8'h40 + sent); sent++;
            end else begin
               wr_e = 1'b0;
            end
            cycle();
         end
         wr_e = 1'b0;
      end
      wait_got(40, 1000, "wrap_strobes");
      for (int k = 0; k < 40; k++)
         check($sformatf("wrap_byte%0d", k), 32'(got[k]), 32'(8'h40 + k));
      repeat (20) cycle();
      check("wrap_end", outs(), expv(1'b0, 8'h67, 5'd0, 1'b1, 1'b0, 1'b0));

      // Reset during WaitBusy with three bytes still queued.
      model_en = 1'b0; busy_drv = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wr_e = 1'b1; wr_d = 8'(8'hC1 + k);
         cycle();
      end
      wr_e = 1'b0; busy_drv = 1'b0;
      cycle();
      check("pre_reset_launch", outs(), expv(1'b1, 8'hC1, 5'd3, 1'b0, 1'b0, 1'b0));
      cycle();
      busy_drv = 1'b1;
      #2 resetn = 1'b0;
      #1 check("async_reset", outs(), expv(1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
      resetn = 1'b1; busy_drv = 1'b0;
      got.delete();
      repeat (20) cycle();
      check("post_reset_quiet", 32'(got.size()), 32'd0);
      check("post_reset_state", outs(), expv(1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0));
      wr_e = 1'b1; wr_d = 8'h5A;
      cycle();
      wr_e = 1'b0;
      check("post_reset_write", 32'(count), 32'd1);
      cycle();
      check("post_reset_send", outs(), expv(1'b1, 8'h5A, 5'd0, 1'b1, 1'b0, 1'b0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte FIFO with drain controller between `uart_rx` and `uart_tx` in the loopback path. It absorbs bytes strobed by the receiver and issues one send strobe per byte to the transmitter, waiting for the transmitter to go idle between bytes. Back-to-back received bytes are no longer lost while the transmitter is busy.

## Interface
- `DEPTH`, 16: number of byte entries; power of two, minimum 2.
- `clk` in 1: single clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `wr_e_i` in 1: one-cycle write strobe, driven by `uart_rx` `done_o`.
- `wr_d_i` in 8: write byte, driven by `uart_rx` `d_o`; valid while `wr_e_i` is high.
- `tx_busy_i` in 1: `uart_tx` `busy_o`.
- `clr_i` in 1: clears the sticky overflow flag.
- `tx_e_o` out 1: one-cycle send strobe to `uart_tx` `e_i`.
- `tx_d_o` out 8: byte to `uart_tx` `d_i`; registered, held stable from the strobe until the next launch.
- `count_o` out $clog2(DEPTH)+1: current occupancy.
- `empty_o` out 1: high when `count_o`==0.
- `full_o` out 1: high when `count_o`==DEPTH.
- `overflow_o` out 1: sticky; set when a byte is dropped.

## Operation
- **Storage:**
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits; pointers wrap modulo DEPTH.
  - Separate occupancy counter.
- **Write:**
  - `wr_e_i` high and not full: store the byte at the write pointer, advance the pointer, increment the count.
  - `wr_e_i` high and full with no pop in the same cycle: drop the byte. Pointers and count are unchanged, and `overflow_o` is set.
  - Full with a pop in the same cycle: accept the write. Count is unchanged.
- **Pop:** occurs only on the IDLE→LAUNCH transition. The head byte is loaded into `tx_d_o`, the read pointer advances, and the count is decremented.
  - A write and a pop in the same cycle leave the count unchanged.
  - A write into an empty FIFO is never popped in the same cycle.
- **Drain FSM:**
  - IDLE: move to LAUNCH when `!empty_o && !tx_busy_i`.
  - LAUNCH: `tx_e_o`=1 for this cycle only. Always move to WAIT_BUSY.
  - WAIT_BUSY: move to WAIT_DONE when `tx_busy_i` goes high.
  - WAIT_DONE: move to IDLE when `tx_busy_i` goes low.
- **`uart_tx` contract:** `busy_o` rises the cycle after `e_i` is sampled, and `d_i` is sampled with `e_i`.
- **Overflow clear:** `clr_i` clears `overflow_o`. If a drop and `clr_i` occur in the same cycle, set wins.
- **Reset:** `resetn` low asynchronously forces the following, aborting any in-flight launch:
  - FSM to IDLE, pointers and count to 0.
  - `tx_e_o`=0, `tx_d_o`=8'h00, `empty_o`=1, `full_o`=0, `overflow_o`=0.
  - Memory contents are not reset.

## Timing
- **Latency:** `wr_e_i` in cycle n into an empty FIFO with the FSM in IDLE and `tx_busy_i` low:
  - `count_o`=1 in n+1.
  - `tx_e_o`=1 and `tx_d_o`=byte in n+2.
  - `count_o`=0 in n+2.
- **Minimum spacing between launches:** launch → WAIT_BUSY → (busy frame) → WAIT_DONE → IDLE → LAUNCH. At least 4 cycles plus the busy duration.
- **Output registration:** all outputs are registered, except `empty_o`/`full_o`, which are decoded from the registered count.
- **Consecutive strobes:** `wr_e_i` may be high on consecutive cycles; each strobe is a distinct byte.

## Configuration
- **`UART_FIFO_OVERFLOW_EN` defined:** sticky `overflow_o` and `clr_i` behave as described above.
- **Not defined:**
  - `overflow_o` is tied to 0 and `clr_i` is ignored.
  - The overflow register is not synthesized.
  - Dropping on full is unchanged.

## Structure
- **Package `uart_pkg`:**
  - `BYTE_W`=8.
  - FSM state enum `drain_state_t` (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE).
- **Sub-module `uart_fifo_ram`:**
  - DEPTH×8 register array.
  - Synchronous write port, asynchronous read at the read pointer.
  - No reset.
- **Top level:** pointers, counter, FSM and flags.

## Test plan
- **Single byte:** `wr_e_i` with 8'hA5 into an empty FIFO, `tx_busy_i` low → `tx_e_o` one cycle at n+2 with `tx_d_o`=8'hA5, `count_o` 1→0.
- **Burst while busy:** hold `tx_busy_i` high, write 8'h01..8'h04 on consecutive cycles → `count_o`=4. Release busy with a transmitter model of 10-cycle frames → four strobes in order 01,02,03,04, each after busy falls.
- **Fill and overflow, DEPTH=16:** write 17 bytes while busy → `full_o`=1, 17th byte dropped, `overflow_o`=1, `count_o`=16. `clr_i` pulse → `overflow_o`=0.
- **Simultaneous write and pop at full:** at the IDLE→LAUNCH cycle with a write → `count_o` stays 16, `overflow_o` stays 0, new byte is drained last.
- **Wrap-around:** stream 40 bytes through DEPTH=16 with a transmitter model → output sequence equals input, no drops.
- **Reset mid-operation:** assert `resetn` low during WAIT_BUSY with 3 bytes queued → all outputs at reset values immediately. After release, nothing is sent until a new write arrives.
